// File: rtl/hazard_unit_p_if.sv
// Pipeline-side bundle for the hazard unit: stage register fields in,
// stall/flush/forward controls and multiply scoreboard status out.
interface hazard_unit_p_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic            id_use_rs, id_use_rt, id_reg_write, id_branch, id_mul, branch_taken;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_rd;
  logic            ex_reg_write, ex_mem2reg;
  logic            mem_reg_write, mem_mem2reg;
  logic [RA_W-1:0] mem_rd;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd;

  logic             stall, flush_d, flush_e, fwd_a_d, fwd_b_d;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             mul_busy, mul_done;
  logic [RA_W-1:0]  mul_rd;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write,
           id_branch, id_mul, branch_taken, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem2reg, mem_reg_write, mem_mem2reg, mem_rd, wb_reg_write, wb_rd,
    input  stall, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
           mul_busy, mul_done, mul_rd, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write,
           id_branch, id_mul, branch_taken, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem2reg, mem_reg_write, mem_mem2reg, mem_rd, wb_reg_write, wb_rd,
    output stall, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
           mul_busy, mul_done, mul_rd, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_p.sv
// Hazard unit for the 5-stage MIPS pipeline: load-use / branch RAW stalls,
// ID and EX forwarding selects, one-deep multiply scoreboard, stall counter.
module hazard_unit_p #(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_unit_p_if.slave hz
);
  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {IDLE, BUSY} st_e;

  st_e              state_q;
  logic [CW-1:0]    cnt_q;
  logic [RA_W-1:0]  mul_rd_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs_v, rt_v, ex_hit, mem_hit, mul_hit, busy;
  logic load_use, br_raw, sb_hit, stall_raw;

  function automatic logic m(input logic [RA_W-1:0] x, input logic [RA_W-1:0] y);
    return (x == y) && (x != '0);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] src, input logic mem_w,
                                       input logic [RA_W-1:0] mem_r, input logic wb_w,
                                       input logic [RA_W-1:0] wb_r);
    if (mem_w && m(mem_r, src)) return 2'b10;
    if (wb_w && m(wb_r, src))   return 2'b01;
    return 2'b00;
  endfunction

  assign rs_v    = hz.id_valid && hz.id_use_rs;
  assign rt_v    = hz.id_valid && hz.id_use_rt;
  assign ex_hit  = (rs_v && m(hz.ex_rd, hz.id_rs))  || (rt_v && m(hz.ex_rd, hz.id_rt));
  assign mem_hit = (rs_v && m(hz.mem_rd, hz.id_rs)) || (rt_v && m(hz.mem_rd, hz.id_rt));
  assign mul_hit = (rs_v && m(mul_rd_q, hz.id_rs))  || (rt_v && m(mul_rd_q, hz.id_rt));
  assign busy    = (state_q == BUSY);

  assign load_use  = hz.ex_mem2reg && ex_hit;
  assign br_raw    = hz.id_valid && hz.id_branch &&
                     ((hz.ex_reg_write && ex_hit) || (hz.mem_mem2reg && mem_hit));
  // RAW on the pending result, WAW on its destination, and the single multiplier itself
  assign sb_hit    = busy && (mul_hit ||
                              (hz.id_valid && hz.id_reg_write && m(mul_rd_q, hz.id_rd)) ||
                              (hz.id_valid && hz.id_mul));
  assign stall_raw = load_use || br_raw || sb_hit;

  assign stall_cnt_d = (stall_raw && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_comb begin
    hz.stall    = stall_raw;
    hz.flush_e  = stall_raw;
    hz.flush_d  = hz.id_branch && hz.branch_taken && !stall_raw;
    hz.fwd_a_d  = rs_v && hz.mem_reg_write && !hz.mem_mem2reg && m(hz.mem_rd, hz.id_rs);
    hz.fwd_b_d  = rt_v && hz.mem_reg_write && !hz.mem_mem2reg && m(hz.mem_rd, hz.id_rt);
    hz.fwd_a_e  = fwd_e(hz.ex_rs, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
    hz.fwd_b_e  = fwd_e(hz.ex_rt, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
    hz.mul_done = busy && (cnt_q == '0);
    if (rst) begin
      hz.stall    = 1'b0;
      hz.flush_d  = 1'b1;
      hz.flush_e  = 1'b1;
      hz.fwd_a_d  = 1'b0;
      hz.fwd_b_d  = 1'b0;
      hz.fwd_a_e  = 2'b00;
      hz.fwd_b_e  = 2'b00;
      hz.mul_done = 1'b0;
    end
  end

  assign hz.mul_busy  = busy;
  assign hz.mul_rd    = mul_rd_q;
  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_rd_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        IDLE: if (hz.id_valid && hz.id_mul && !stall_raw) begin
          state_q  <= BUSY;
          cnt_q    <= CW'(MUL_LAT - 1);
          mul_rd_q <= hz.id_rd;
        end
        BUSY: if (cnt_q == '0) state_q <= IDLE;
              else             cnt_q   <= cnt_q - CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: directed scenarios plus random traffic against a
// cycle-indexed reference model of the hazard rules and multiply timing.
module tb_hazard_unit_p;
  localparam int RA_W = 5, MUL_LAT = 4, CNT_W = 16;

  typedef struct packed {
    logic stall, flush_d, flush_e, fa_d, fb_d;
    logic [1:0] fa_e, fb_e;
    logic busy, done;
    logic [RA_W-1:0] mrd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_p_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();
  hazard_unit_p_if #(.RA_W(RA_W), .CNT_W(2))     hz2 ();

  hazard_unit_p #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) u0 (.clk(clk), .rst(rst), .hz(hz.slave));
  hazard_unit_p #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .CNT_W(2))     u1 (.clk(clk), .rst(rst), .hz(hz2.slave));

  assign hz2.id_valid = hz.id_valid;        assign hz2.id_rs = hz.id_rs;
  assign hz2.id_rt = hz.id_rt;              assign hz2.id_rd = hz.id_rd;
  assign hz2.id_use_rs = hz.id_use_rs;      assign hz2.id_use_rt = hz.id_use_rt;
  assign hz2.id_reg_write = hz.id_reg_write; assign hz2.id_branch = hz.id_branch;
  assign hz2.id_mul = hz.id_mul;            assign hz2.branch_taken = hz.branch_taken;
  assign hz2.ex_rs = hz.ex_rs;              assign hz2.ex_rt = hz.ex_rt;
  assign hz2.ex_rd = hz.ex_rd;              assign hz2.ex_reg_write = hz.ex_reg_write;
  assign hz2.ex_mem2reg = hz.ex_mem2reg;    assign hz2.mem_reg_write = hz.mem_reg_write;
  assign hz2.mem_mem2reg = hz.mem_mem2reg;  assign hz2.mem_rd = hz.mem_rd;
  assign hz2.wb_reg_write = hz.wb_reg_write; assign hz2.wb_rd = hz.wb_rd;

  // reference model state: cycle index, issue cycle of the last multiply, counters
  int cyc, mul_t, scnt, scnt2, vecs, errs;
  bit m_act;
  logic [RA_W-1:0] m_rd;

  function automatic bit mm(input logic [RA_W-1:0] x, input logic [RA_W-1:0] y);
    return (x == y) && (x != 0);
  endfunction

  function automatic bit id_hit(input logic [RA_W-1:0] r);
    return (hz.id_valid && hz.id_use_rs && mm(r, hz.id_rs)) ||
           (hz.id_valid && hz.id_use_rt && mm(r, hz.id_rt));
  endfunction

  function automatic bit m_busy();
    return m_act && cyc >= mul_t + 1 && cyc <= mul_t + MUL_LAT;
  endfunction

  function automatic logic [1:0] ref_fe(input logic [RA_W-1:0] src);
    if (hz.mem_reg_write && mm(hz.mem_rd, src)) return 2'b10;
    if (hz.wb_reg_write && mm(hz.wb_rd, src))   return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit lu, br, sb;
    e.busy = m_busy();
    e.done = m_act && (cyc == mul_t + MUL_LAT);
    e.mrd  = m_rd;
    lu = hz.ex_mem2reg && id_hit(hz.ex_rd);
    br = hz.id_valid && hz.id_branch &&
         ((hz.ex_reg_write && id_hit(hz.ex_rd)) || (hz.mem_mem2reg && id_hit(hz.mem_rd)));
    sb = e.busy && (id_hit(m_rd) || (hz.id_valid && hz.id_reg_write && mm(m_rd, hz.id_rd)) ||
                    (hz.id_valid && hz.id_mul));
    e.stall   = lu || br || sb;
    e.flush_e = e.stall;
    e.flush_d = hz.id_branch && hz.branch_taken && !e.stall;
    e.fa_d = hz.id_valid && hz.id_use_rs && hz.mem_reg_write && !hz.mem_mem2reg && mm(hz.mem_rd, hz.id_rs);
    e.fb_d = hz.id_valid && hz.id_use_rt && hz.mem_reg_write && !hz.mem_mem2reg && mm(hz.mem_rd, hz.id_rt);
    e.fa_e = ref_fe(hz.ex_rs);
    e.fb_e = ref_fe(hz.ex_rt);
    if (rst) begin
      e.stall = 0; e.flush_d = 1; e.flush_e = 1; e.fa_d = 0; e.fb_d = 0;
      e.fa_e = 0; e.fb_e = 0; e.done = 0;
    end
    return e;
  endfunction

  // advance one clock, updating the model with what this cycle decided
  task automatic step();
    exp_t e;
    bit issue;
    e = model();
    issue = !m_busy() && hz.id_valid && hz.id_mul && !e.stall;
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_rd = 0; scnt = 0; scnt2 = 0;
    end else begin
      if (e.stall) begin
        if (scnt < 65535) scnt++;
        if (scnt2 < 3) scnt2++;
      end
      if (issue) begin m_act = 1; mul_t = cyc; m_rd = hz.id_rd; end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    hz.id_valid = 0; hz.id_rs = 0; hz.id_rt = 0; hz.id_rd = 0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_reg_write = 0; hz.id_branch = 0; hz.id_mul = 0; hz.branch_taken = 0;
    hz.ex_rs = 0; hz.ex_rt = 0; hz.ex_rd = 0; hz.ex_reg_write = 0; hz.ex_mem2reg = 0;
    hz.mem_reg_write = 0; hz.mem_mem2reg = 0; hz.mem_rd = 0; hz.wb_reg_write = 0; hz.wb_rd = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1;
    hz.ex_mem2reg = 1; hz.ex_rd = 2; hz.id_valid = 1; hz.id_use_rs = 1; hz.id_rs = 2;
    hz.mem_reg_write = 1; hz.mem_rd = 3; hz.ex_rt = 3;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", hz.stall); end
    vecs++; if (hz.flush_d !== 1'b1 || hz.flush_e !== 1'b1) begin errs++; $display("FAIL reset_flush got %b%b want 11", hz.flush_d, hz.flush_e); end
    vecs++; if (hz.fwd_b_e !== 2'b00 || hz.mul_done !== 1'b0) begin errs++; $display("FAIL reset_fwd got %b/%b want 00/0", hz.fwd_b_e, hz.mul_done); end
    step(); rst = 0; idle_in();
    @(negedge clk);
    vecs++; if (hz.stall_cnt !== 16'd0 || hz.mul_busy !== 1'b0 || hz.mul_rd !== 5'd0) begin
      errs++; $display("FAIL reset_state got cnt=%0d busy=%b rd=%0d want 0/0/0", hz.stall_cnt, hz.mul_busy, hz.mul_rd); end
    vecs++; if (hz.flush_d !== 1'b0 || hz.flush_e !== 1'b0) begin errs++; $display("FAIL post_reset_flush got %b%b want 00", hz.flush_d, hz.flush_e); end
    step();
  endtask

  task automatic test_fwd_ex();
    idle_in(); hz.mem_reg_write = 1; hz.mem_rd = 3; hz.wb_reg_write = 1; hz.wb_rd = 3; hz.ex_rs = 3; hz.ex_rt = 3;
    @(negedge clk);
    vecs++; if (hz.fwd_a_e !== 2'b10 || hz.fwd_b_e !== 2'b10) begin errs++; $display("FAIL fwd_mem_prio got %b/%b want 10/10", hz.fwd_a_e, hz.fwd_b_e); end
    step();
    hz.ex_rs = 0; hz.mem_rd = 0;
    @(negedge clk);
    vecs++; if (hz.fwd_a_e !== 2'b00 || hz.fwd_b_e !== 2'b01) begin errs++; $display("FAIL fwd_zero_wb got %b/%b want 00/01", hz.fwd_a_e, hz.fwd_b_e); end
    step();
  endtask

  task automatic test_load_use();
    idle_in(); hz.ex_mem2reg = 1; hz.ex_reg_write = 1; hz.ex_rd = 2;
    hz.id_valid = 1; hz.id_use_rs = 1; hz.id_rs = 2; hz.id_use_rt = 1; hz.id_rt = 7; hz.id_rd = 8; hz.id_reg_write = 1;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b1 || hz.flush_e !== 1'b1) begin errs++; $display("FAIL lu_stall got %b%b want 11", hz.stall, hz.flush_e); end
    step();
    hz.ex_mem2reg = 0; hz.ex_reg_write = 0; hz.ex_rd = 0;
    hz.mem_reg_write = 1; hz.mem_mem2reg = 1; hz.mem_rd = 2;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.flush_e !== 1'b0 || hz.fwd_a_d !== 1'b0) begin
      errs++; $display("FAIL lu_release got %b%b%b want 000", hz.stall, hz.flush_e, hz.fwd_a_d); end
    step();
    idle_in(); hz.ex_rs = 2; hz.ex_rt = 7; hz.ex_reg_write = 1; hz.ex_rd = 8; hz.wb_reg_write = 1; hz.wb_rd = 2;
    @(negedge clk);
    vecs++; if (hz.fwd_a_e !== 2'b01 || hz.fwd_b_e !== 2'b00) begin errs++; $display("FAIL lu_fwd_wb got %b/%b want 01/00", hz.fwd_a_e, hz.fwd_b_e); end
    step();
  endtask

  task automatic test_branch();
    idle_in(); hz.id_valid = 1; hz.id_branch = 1; hz.branch_taken = 1; hz.id_use_rs = 1; hz.id_rs = 4;
    hz.id_use_rt = 1; hz.id_rt = 0; hz.ex_reg_write = 1; hz.ex_rd = 4;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b1 || hz.flush_e !== 1'b1 || hz.flush_d !== 1'b0) begin
      errs++; $display("FAIL br_stall got s=%b fe=%b fd=%b want 1/1/0", hz.stall, hz.flush_e, hz.flush_d); end
    step();
    hz.ex_reg_write = 0; hz.ex_rd = 0; hz.mem_reg_write = 1; hz.mem_rd = 4;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.fwd_a_d !== 1'b1 || hz.fwd_b_d !== 1'b0 || hz.flush_d !== 1'b1) begin
      errs++; $display("FAIL br_fwd got s=%b fa=%b fb=%b fd=%b want 0/1/0/1", hz.stall, hz.fwd_a_d, hz.fwd_b_d, hz.flush_d); end
    step();
    idle_in();
  endtask

  task automatic test_mul();
    do_reset();
    idle_in(); hz.id_valid = 1; hz.id_mul = 1; hz.id_reg_write = 1; hz.id_rd = 5; hz.id_use_rs = 1; hz.id_rs = 1;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.mul_busy !== 1'b0) begin errs++; $display("FAIL mul_issue got s=%b b=%b want 0/0", hz.stall, hz.mul_busy); end
    step();
    idle_in(); hz.id_valid = 1; hz.id_use_rs = 1; hz.id_rs = 5; hz.id_rd = 6; hz.id_reg_write = 1;
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      vecs++; if (hz.mul_busy !== 1'b1 || hz.stall !== 1'b1 || hz.mul_done !== (k == MUL_LAT) || hz.mul_rd !== 5'd5) begin
        errs++; $display("FAIL mul_dep t+%0d got b=%b s=%b d=%b rd=%0d want 1/1/%0d/5", k, hz.mul_busy, hz.stall, hz.mul_done, hz.mul_rd, k == MUL_LAT); end
      step();
    end
    @(negedge clk);
    vecs++; if (hz.mul_busy !== 1'b0 || hz.stall !== 1'b0 || hz.mul_done !== 1'b0 || hz.stall_cnt !== 16'd4) begin
      errs++; $display("FAIL mul_release got b=%b s=%b d=%b cnt=%0d want 0/0/0/4", hz.mul_busy, hz.stall, hz.mul_done, hz.stall_cnt); end
    step(); idle_in();
  endtask

  task automatic test_mul_hazards();
    do_reset();
    idle_in(); hz.id_valid = 1; hz.id_mul = 1; hz.id_reg_write = 1; hz.id_rd = 5;
    step();
    hz.id_rd = 9;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b1) begin errs++; $display("FAIL mul_struct got %b want 1", hz.stall); end
    step();
    hz.id_mul = 0; hz.id_rd = 5; hz.id_use_rs = 1; hz.id_rs = 1; hz.id_use_rt = 1; hz.id_rt = 2;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b1) begin errs++; $display("FAIL mul_waw got %b want 1", hz.stall); end
    step();
    hz.id_rd = 6;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.mul_busy !== 1'b1) begin errs++; $display("FAIL mul_indep got s=%b b=%b want 0/1", hz.stall, hz.mul_busy); end
    step();
    hz.id_mul = 1; hz.id_rd = 9;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b1 || hz.mul_done !== 1'b1) begin errs++; $display("FAIL mul_done_struct got s=%b d=%b want 1/1", hz.stall, hz.mul_done); end
    step();
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.mul_busy !== 1'b0) begin errs++; $display("FAIL mul_reissue got s=%b b=%b want 0/0", hz.stall, hz.mul_busy); end
    step(); idle_in();
    @(negedge clk);
    vecs++; if (hz.mul_busy !== 1'b1 || hz.mul_rd !== 5'd9) begin errs++; $display("FAIL mul_second got b=%b rd=%0d want 1/9", hz.mul_busy, hz.mul_rd); end
    step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    idle_in(); hz.id_valid = 1; hz.id_mul = 1; hz.id_reg_write = 1; hz.id_rd = 5;
    step(); idle_in(); step();
    rst = 1; hz.id_valid = 1; hz.id_use_rs = 1; hz.id_rs = 5;
    @(negedge clk);
    vecs++; if (hz.stall !== 1'b0 || hz.mul_done !== 1'b0) begin errs++; $display("FAIL abort_forced got s=%b d=%b want 0/0", hz.stall, hz.mul_done); end
    step(); rst = 0;
    for (int k = 3; k <= MUL_LAT; k++) begin
      @(negedge clk);
      vecs++; if (hz.mul_busy !== 1'b0 || hz.mul_done !== 1'b0 || hz.stall !== 1'b0 || hz.stall_cnt !== 16'd0) begin
        errs++; $display("FAIL abort t+%0d got b=%b d=%b s=%b cnt=%0d want 0/0/0/0", k, hz.mul_busy, hz.mul_done, hz.stall, hz.stall_cnt); end
      step();
    end
    idle_in();
  endtask

  task automatic test_saturate();
    do_reset();
    idle_in(); hz.ex_mem2reg = 1; hz.ex_rd = 3; hz.id_valid = 1; hz.id_use_rt = 1; hz.id_rt = 3;
    for (int k = 0; k < 5; k++) step();
    idle_in();
    @(negedge clk);
    vecs++; if (hz2.stall_cnt !== 2'd3) begin errs++; $display("FAIL sat_cnt2 got %0d want 3", hz2.stall_cnt); end
    vecs++; if (hz.stall_cnt !== 16'd5) begin errs++; $display("FAIL sat_cnt16 got %0d want 5", hz.stall_cnt); end
    step();
  endtask

  function automatic logic [RA_W-1:0] rreg();
    return ($urandom_range(0, 7) == 0) ? RA_W'($urandom) : RA_W'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    exp_t e, o;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      hz.id_valid = ($urandom_range(0, 4) != 0); hz.id_rs = rreg(); hz.id_rt = rreg(); hz.id_rd = rreg();
      hz.id_use_rs = 1'($urandom); hz.id_use_rt = 1'($urandom); hz.id_reg_write = 1'($urandom);
      hz.id_branch = ($urandom_range(0, 3) == 0); hz.id_mul = ($urandom_range(0, 5) == 0); hz.branch_taken = 1'($urandom);
      hz.ex_rs = rreg(); hz.ex_rt = rreg(); hz.ex_rd = rreg(); hz.ex_reg_write = 1'($urandom);
      hz.ex_mem2reg = ($urandom_range(0, 3) == 0);
      hz.mem_reg_write = 1'($urandom); hz.mem_mem2reg = ($urandom_range(0, 3) == 0); hz.mem_rd = rreg();
      hz.wb_reg_write = 1'($urandom); hz.wb_rd = rreg();
      @(negedge clk);
      e = model();
      o = '{hz.stall, hz.flush_d, hz.flush_e, hz.fwd_a_d, hz.fwd_b_d, hz.fwd_a_e, hz.fwd_b_e, hz.mul_busy, hz.mul_done, hz.mul_rd};
      vecs++; if (o !== e) begin errs++; $display("FAIL random cyc %0d got %h want %h", cyc, o, e); end
      vecs++; if (hz.stall_cnt !== CNT_W'(scnt) || hz2.stall_cnt !== 2'(scnt2)) begin
        errs++; $display("FAIL random_cnt cyc %0d got %0d/%0d want %0d/%0d", cyc, hz.stall_cnt, hz2.stall_cnt, scnt, scnt2); end
      step();
    end
    rst = 0; idle_in();
  endtask

  initial begin
    vecs = 0; errs = 0; cyc = 0; mul_t = -100; m_act = 0; m_rd = 0; scnt = 0; scnt2 = 0;
    rst = 1; idle_in();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_branch();
    test_mul();
    test_mul_hazards();
    test_reset_abort();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
